bitstream_self_writer: RTL and testbench

Hardware initiator for the fabric's self-write configuration port. It reads a bitstream byte-by-byte from a synchronous byte memory and packs every four bytes big-endian into a 32-bit word. Each word is presented on `SelfWriteData` and pulsed with a one-cycle `SelfWriteStrobe`, using the same setup/hold spacing the fabric config logic expects. It sits beside `eFPGA_top` and replaces bench- or CPU-driven bitstream loading.

---
 rtl/bitstream_self_writer_if.sv | 36 +++
 rtl/bitstream_self_writer.sv | 146 ++++++++++++++
 tb/tb_bitstream_self_writer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitstream_self_writer_if.sv
// Bus bundle between the bitstream self-writer, its byte memory and the fabric.
// The checksum signal exists only when BITSTREAM_CHECKSUM_EN is defined.
interface bitstream_self_writer_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [ADDR_W:0]   len_bytes;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rdata;
    logic [31:0]       SelfWriteData;
    logic              SelfWriteStrobe;
    logic              busy;
    logic              done;
`ifdef BITSTREAM_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    modport master (
        input  start, len_bytes, mem_rdata,
        output mem_addr, mem_rd_en, SelfWriteData, SelfWriteStrobe,
        output busy, done
`ifdef BITSTREAM_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, len_bytes, mem_rdata,
        input  mem_addr, mem_rd_en, SelfWriteData, SelfWriteStrobe,
        input  busy, done
`ifdef BITSTREAM_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/bitstream_self_writer.sv
// Streams a byte memory into big-endian 32-bit self-write words with strobes.
// Optional: define BITSTREAM_CHECKSUM_EN for a 16-bit sum of bytes read.
module bitstream_self_writer #(
    parameter int ADDR_W    = 14,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic CLK,
    input  logic reset,
    bitstream_self_writer_if.master bus
);
    localparam int PW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cnt;
    logic [PW-1:0] r_len;
    logic [PW-1:0] r_ptr;
    logic [23:0]   r_pack;
    logic          r_rd_q;
    logic [31:0]   r_data;
    logic          w_rd_en;
    logic          w_accept;
    logic [PW-1:0] w_rd_ptr;
    logic [7:0]    w_byte;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_rd_ptr = r_ptr + PW'(r_cnt[1:0]);
    // Bytes past the end were never read, so they pack as zero.
    assign w_byte   = r_rd_q ? bus.mem_rdata : 8'h00;

    assign bus.SelfWriteData = r_data;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len_bytes != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (r_cnt == 8'd4) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == 8'(SETUP_CYC - 1)) begin
                    w_next = S_STROBE;
                end
            end
            S_STROBE: w_next = S_HOLD;
            S_HOLD: begin
                if (r_cnt == 8'(HOLD_CYC - 1)) begin
                    w_next = (r_ptr < r_len) ? S_FETCH : S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en             = 1'b0;
        bus.mem_rd_en       = 1'b0;
        bus.mem_addr        = '0;
        bus.SelfWriteStrobe = 1'b0;
        bus.busy            = 1'b0;
        bus.done            = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_rd_en       = (r_cnt < 8'd4) && (w_rd_ptr < r_len);
                bus.mem_rd_en = w_rd_en;
                bus.mem_addr  = w_rd_en ? w_rd_ptr[ADDR_W-1:0] : '0;
                bus.busy      = 1'b1;
            end
            S_SETUP: bus.busy = 1'b1;
            S_STROBE: begin
                bus.SelfWriteStrobe = 1'b1;
                bus.busy            = 1'b1;
            end
            S_HOLD: bus.busy = 1'b1;
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_ptr  <= '0;
            r_pack <= '0;
            r_rd_q <= 1'b0;
            r_data <= '0;
        end else begin
            r_rd_q <= w_rd_en;
            r_cnt  <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            if (w_accept) begin
                r_len <= bus.len_bytes;
                r_ptr <= '0;
            end
            if (r_state == S_FETCH && r_cnt != 8'd0) begin
                r_pack <= {r_pack[15:0], w_byte};
                if (r_cnt == 8'd4) begin
                    r_data <= {r_pack, w_byte};
                    r_ptr  <= r_ptr + PW'(4);
                end
            end
        end
    end

`ifdef BITSTREAM_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (r_state == S_FETCH && r_rd_q) begin
            r_sum <= r_sum + {8'h00, bus.mem_rdata};
        end
    end

    assign bus.checksum = r_sum;
`endif

endmodule

// File: tb/tb_bitstream_self_writer.sv
// Directed + randomized bench for bitstream_self_writer with a byte-level model.
// Checksum checks are active when BITSTREAM_CHECKSUM_EN is defined.
module tb_bitstream_self_writer;
    localparam int ADDR_W    = 14;
    localparam int SETUP_CYC = 2;
    localparam int HOLD_CYC  = 2;
    localparam int MEM_N     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] mem [MEM_N];

    bitstream_self_writer_if #(.ADDR_W(ADDR_W)) bus ();

    bitstream_self_writer #(
        .ADDR_W(ADDR_W),
        .SETUP_CYC(SETUP_CYC),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .CLK(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Monitor state, sampled on the falling edge
    logic [31:0] q_word [$];
    int          q_scyc [$];
    int          q_addr [$];
    int          rd_cnt, done_cnt, done_cyc, first_rd;
    int          consec_err, setup_err, hold_err, done_busy_err;
    int          stable_cnt, hold_left;
    logic [31:0] prev_data, hold_word;
    logic        prev_strobe;

    task automatic clr();
        q_word.delete();
        q_scyc.delete();
        q_addr.delete();
        rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_rd = -1;
        consec_err = 0; setup_err = 0; hold_err = 0; done_busy_err = 0;
        hold_left = 0;
    endtask

    always @(negedge clk) begin
        if (bus.mem_rd_en) begin
            rd_cnt++;
            q_addr.push_back(int'(bus.mem_addr));
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.SelfWriteStrobe) begin
            q_word.push_back(bus.SelfWriteData);
            q_scyc.push_back(cyc);
            if (prev_strobe) consec_err++;
            if (bus.SelfWriteData !== prev_data || stable_cnt + 1 < SETUP_CYC)
                setup_err++;
            hold_left = HOLD_CYC;
            hold_word = bus.SelfWriteData;
        end else if (hold_left > 0) begin
            if (bus.SelfWriteData !== hold_word) hold_err++;
            hold_left--;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.busy) done_busy_err++;
        end
        stable_cnt  = (bus.SelfWriteData === prev_data) ? stable_cnt + 1 : 0;
        prev_data   = bus.SelfWriteData;
        prev_strobe = bus.SelfWriteStrobe;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: word i is bytes 4i..4i+3 big-endian, zero past len
    function automatic logic [31:0] exp_word(input int len, input int i);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++) begin
            int a = 4 * i + b;
            w = {w[23:0], (a < len) ? mem[a] : 8'h00};
        end
        return w;
    endfunction

    function automatic logic [15:0] exp_sum(input int len);
        int s = 0;
        for (int a = 0; a < len; a++) s += int'(mem[a]);
        return 16'(s);
    endfunction

    task automatic check_words(input string tag, input int len);
        int nw  = (len + 3) / 4;
        int bad = 0;
        check({tag, "_nwords"}, q_word.size(), nw);
        foreach (q_word[i]) begin
            if (i < nw && q_word[i] !== exp_word(len, i)) bad++;
        end
        check({tag, "_word_mismatches"}, bad, 0);
        check({tag, "_consec_strobe"}, consec_err, 0);
        check({tag, "_setup_stable"}, setup_err, 0);
        check({tag, "_hold_stable"}, hold_err, 0);
    endtask

    task automatic do_start(input int len, output int t0);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.len_bytes = 15'(len);
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n  = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done_cnt != d0, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t0, amax, len;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.len_bytes = '0;
        bus.mem_rdata = '0;
        prev_data = '0; prev_strobe = 1'b0; stable_cnt = 0;
        for (int a = 0; a < MEM_N; a++) mem[a] = 8'($urandom);
        clr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", bus.SelfWriteData, 0);
        check("rst_strobe", bus.SelfWriteStrobe, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
`ifdef BITSTREAM_CHECKSUM_EN
        check("rst_checksum", bus.checksum, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // 8 bytes 00..07
        for (int a = 0; a < 8; a++) mem[a] = 8'(a);
        clr();
        do_start(8, t0);
        wait_done("t8", 100);
        check("t8_w0", q_word.size() > 0 ? q_word[0] : 32'hx, 32'h0001_0203);
        check("t8_w1", q_word.size() > 1 ? q_word[1] : 32'hx, 32'h0405_0607);
        check_words("t8", 8);
        check("t8_first_rd", first_rd, t0 + 1);
        check("t8_strobe0_cyc", q_scyc.size() > 0 ? q_scyc[0] : -1, t0 + 8);
        check("t8_spacing", q_scyc.size() > 1 ? q_scyc[1] - q_scyc[0] : -1, 10);
        check("t8_done_lat", q_scyc.size() > 1 ? done_cyc - q_scyc[1] : -1, 3);
        check("t8_done_busy", done_busy_err, 0);
        check("t8_data_kept", bus.SelfWriteData, 32'h0405_0607);
`ifdef BITSTREAM_CHECKSUM_EN
        check("t8_checksum", bus.checksum, 16'h001C);
`endif

        // 6 bytes AA..FF, tail padded, addresses 6/7 untouched
        for (int a = 0; a < 6; a++) mem[a] = 8'(8'hAA + 8'(17 * a));
        mem[6] = 8'h11;
        mem[7] = 8'h22;
        clr();
        do_start(6, t0);
        wait_done("t6", 100);
        check("t6_w0", q_word.size() > 0 ? q_word[0] : 32'hx, 32'hAABB_CCDD);
        check("t6_w1", q_word.size() > 1 ? q_word[1] : 32'hx, 32'hEEFF_0000);
        check("t6_rd_cnt", rd_cnt, 6);
        amax = -1;
        foreach (q_addr[i]) if (q_addr[i] > amax) amax = q_addr[i];
        check("t6_max_addr", amax, 5);
`ifdef BITSTREAM_CHECKSUM_EN
        check("t6_checksum", bus.checksum, exp_sum(6));
`endif

        // zero length
        clr();
        do_start(0, t0);
        wait_done("t0", 20);
        check("t0_done_cyc", done_cyc, t0 + 1);
        check("t0_rd_cnt", rd_cnt, 0);
        check("t0_strobes", q_word.size(), 0);
        check("t0_data", bus.SelfWriteData, 32'hEEFF_0000);

        // start re-pulsed mid-load is ignored
        for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
        clr();
        do_start(16, t0);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.len_bytes = 15'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("t16", 200);
        check_words("t16", 16);
        check("t16_done_cnt", done_cnt, 1);

        // reset during SETUP of word 2
        clr();
        do_start(16, t0);
        repeat (15) @(posedge clk);
        #1;
        check("trst_strobes_before", q_word.size(), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("trst_strobe", bus.SelfWriteStrobe, 0);
        check("trst_data", bus.SelfWriteData, 0);
        check("trst_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("trst_no_more_strobes", q_word.size(), 1);
        clr();
        do_start(4, t0);
        wait_done("trl", 100);
        check("trl_addr0", q_addr.size() > 0 ? q_addr[0] : -1, 0);
        check_words("trl", 4);

        // random short loads
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 64);
            for (int a = 0; a < 72; a++) mem[a] = 8'($urandom);
            clr();
            do_start(len, t0);
            wait_done("trand", 300);
            check_words("trand", len);
            check("trand_rd_cnt", rd_cnt, len);
`ifdef BITSTREAM_CHECKSUM_EN
            check("trand_checksum", bus.checksum, exp_sum(len));
`endif
        end

        // full-size load
        for (int a = 0; a < MEM_N; a++) mem[a] = 8'($urandom);
        clr();
        do_start(MEM_N, t0);
        wait_done("tfull", 45000);
        check_words("tfull", MEM_N);
        check("tfull_rd_cnt", rd_cnt, MEM_N);
        check("tfull_done_busy", done_busy_err, 0);
`ifdef BITSTREAM_CHECKSUM_EN
        check("tfull_checksum", bus.checksum, exp_sum(MEM_N));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
